lift_occupancy_display: RTL and testbench

//  Consumer end of the lift occupancy counter: samples the 4-bit BCD count (Q3..Q0) and the Full/Empty flags.

---
 rtl/lift_occupancy_display_pkg.sv | 37 +++
 rtl/lift_occupancy_display_bcd_to_7seg.sv | 19 +
 rtl/lift_occupancy_display.sv | 229 ++++++++++++++++++++++
 tb/tb_lift_occupancy_display.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/lift_occupancy_display_pkg.sv
// Shared definitions for the lift occupancy display.
//   - FSM state encodings (state_t)
//   - Segment constants (SEG_BLANK, SEG_E) and the 0..9 digit patterns
// Segment bit order is {g,f,e,d,c,b,a}, active-high.
package lift_occupancy_display_pkg;

  typedef enum logic [2:0] {
    S_EMPTY     = 3'd0,
    S_OCC       = 3'd1,
    S_FULL_BEEP = 3'd2,
    S_FULL      = 3'd3,
    S_ERR       = 3'd4
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_E     = 7'h79;

  // Digit glyph for a BCD code; codes above 9 return blank.
  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/lift_occupancy_display_bcd_to_7seg.sv
// BCD to 7-segment decoder (purely combinational).
// Ports:
//   code  in  4  BCD digit
//   seg   out 7  {g,f,e,d,c,b,a}, active-high; "E" glyph for codes above 9
//   valid out 1  high when code is 0..9
module bcd_to_7seg
  import lift_occupancy_display_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg,
  output logic       valid
);

  always_comb begin
    valid = (code <= 4'd9);
    seg   = valid ? digit_seg(code) : SEG_E;
  end

endmodule

// File: rtl/lift_occupancy_display.sv
// Lift occupancy display: samples the BCD occupancy count and Full/Empty
// flags, drives a 7-segment digit, Full/Empty LEDs, a buzzer and an error flag.
// A timed beep sounds on entry to Full and the digit blinks while Full.
//
// Two register stages: stage 1 samples the inputs, stage 2 registers every
// output. The FSM state register updates on the same edge as stage 2, so the
// outputs are decoded from the next state and an input change shows up on
// the outputs exactly two cycles later.
//
// Optional feature macro: LIFT_DISP_CHANGE_CHIRP_EN -- short buzzer chirp on
// any count change while not Full and not in error.
//
// Ports:
//   CLK        in   1  system clock, rising edge
//   RST        in   1  asynchronous active-low reset
//   Q0..Q3     in   1  occupancy count bits, Q0 = LSB
//   Full       in   1  count == MAX_COUNT
//   Empty      in   1  count == 0
//   SEG        out  7  segments {g,f,e,d,c,b,a}, active-high
//   LED_FULL   out  1  follows Full
//   LED_EMPTY  out  1  follows Empty
//   BUZZ       out  1  buzzer drive
//   ERR        out  1  out-of-range code or inconsistent flags
//   dbg_state  out  3  current FSM state
module lift_occupancy_display
  import lift_occupancy_display_pkg::*;
#(
  parameter int BLINK_HALF  = 12_500_000,
  parameter int BEEP_CYCLES = 25_000_000,
  parameter int MAX_COUNT   = 9
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Q0,
  input  logic       Q1,
  input  logic       Q2,
  input  logic       Q3,
  input  logic       Full,
  input  logic       Empty,
  output logic [6:0] SEG,
  output logic       LED_FULL,
  output logic       LED_EMPTY,
  output logic       BUZZ,
  output logic       ERR,
  output state_t     dbg_state
);

  localparam int BKW = (BLINK_HALF > 2) ? $clog2(BLINK_HALF) : 1;
  localparam int BPW = (BEEP_CYCLES > 2) ? $clog2(BEEP_CYCLES) : 1;
  localparam logic [BKW-1:0] BLINK_LAST = BKW'(BLINK_HALF - 1);
  localparam logic [BPW-1:0] BEEP_LAST  = BPW'(BEEP_CYCLES - 1);
  localparam logic [3:0]     MAX_CODE   = 4'(MAX_COUNT);

  // Stage 1: input sample
  logic [3:0] cnt_s1;
  logic       full_s1;
  logic       empty_s1;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_s1   <= 4'd0;
      full_s1  <= 1'b0;
      empty_s1 <= 1'b1;
    end else begin
      cnt_s1   <= {Q3, Q2, Q1, Q0};
      full_s1  <= Full;
      empty_s1 <= Empty;
    end
  end

  // Decoder between stage 1 and stage 2
  logic [6:0] dec_seg;
  logic       dec_valid;

  bcd_to_7seg u_dec (
    .code  (cnt_s1),
    .seg   (dec_seg),
    .valid (dec_valid)
  );

  // FSM and timers
  state_t         state, state_next;
  logic [BPW-1:0] beep_cnt, beep_cnt_next;
  logic [BKW-1:0] blink_cnt, blink_cnt_next;
  logic           phase, phase_next;
  logic           err_cond;
  logic           in_full, next_full, entering_full;

  always_comb begin
    // Out-of-range code, both flags, or a flag that disagrees with the count.
    err_cond = (cnt_s1 > MAX_CODE) || (full_s1 && empty_s1) ||
               (full_s1 != (cnt_s1 == MAX_CODE)) ||
               (empty_s1 != (cnt_s1 == 4'd0));
    in_full  = (state == S_FULL_BEEP) || (state == S_FULL);

    state_next = state;
    if (err_cond)
      state_next = S_ERR;
    else if (full_s1 && !in_full)
      state_next = S_FULL_BEEP;
    else if (full_s1 && (state == S_FULL_BEEP) && (beep_cnt == BEEP_LAST))
      state_next = S_FULL;
    else if (full_s1)
      state_next = state;
    else if (empty_s1)
      state_next = S_EMPTY;
    else
      state_next = S_OCC;

    next_full     = (state_next == S_FULL_BEEP) || (state_next == S_FULL);
    entering_full = next_full && !in_full;

    // Beep counter only runs inside S_FULL_BEEP and restarts on every entry.
    beep_cnt_next = '0;
    if ((state_next == S_FULL_BEEP) && !entering_full)
      beep_cnt_next = beep_cnt + 1'b1;

    // Blink timer: cleared on entry so the first half-period shows the digit.
    blink_cnt_next = '0;
    phase_next     = 1'b0;
    if (next_full && !entering_full) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt_next = '0;
        phase_next     = ~phase;
      end else begin
        blink_cnt_next = blink_cnt + 1'b1;
        phase_next     = phase;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= S_EMPTY;
      beep_cnt  <= '0;
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else begin
      state     <= state_next;
      beep_cnt  <= beep_cnt_next;
      blink_cnt <= blink_cnt_next;
      phase     <= phase_next;
    end
  end

  assign dbg_state = state;

  // Buzzer source
  logic buzz_next;

`ifdef LIFT_DISP_CHANGE_CHIRP_EN
  localparam int CHIRP_LEN = (BEEP_CYCLES / 16 > 0) ? BEEP_CYCLES / 16 : 1;
  localparam int CCW       = (CHIRP_LEN > 2) ? $clog2(CHIRP_LEN) : 1;
  localparam logic [CCW-1:0] CHIRP_LAST = CCW'(CHIRP_LEN - 1);

  logic [3:0]     cnt_prev;
  logic           chirp_on, chirp_on_next;
  logic [CCW-1:0] chirp_cnt, chirp_cnt_next;
  logic           quiet;

  always_comb begin
    quiet          = (state_next == S_EMPTY) || (state_next == S_OCC);
    chirp_on_next  = chirp_on;
    chirp_cnt_next = chirp_cnt;
    if (!quiet) begin
      // Full beep or error cancels any chirp in progress.
      chirp_on_next  = 1'b0;
      chirp_cnt_next = '0;
    end else if (cnt_s1 != cnt_prev) begin
      chirp_on_next  = 1'b1;
      chirp_cnt_next = '0;
    end else if (chirp_on) begin
      if (chirp_cnt == CHIRP_LAST) begin
        chirp_on_next  = 1'b0;
        chirp_cnt_next = '0;
      end else begin
        chirp_cnt_next = chirp_cnt + 1'b1;
      end
    end
    buzz_next = (state_next == S_FULL_BEEP) || chirp_on_next;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_prev  <= 4'd0;
      chirp_on  <= 1'b0;
      chirp_cnt <= '0;
    end else begin
      cnt_prev  <= cnt_s1;
      chirp_on  <= chirp_on_next;
      chirp_cnt <= chirp_cnt_next;
    end
  end
`else
  always_comb begin
    buzz_next = (state_next == S_FULL_BEEP);
  end
`endif

  // Stage 2: registered outputs decoded from the next state
  logic [6:0] seg_next;

  always_comb begin
    seg_next = dec_seg;
    if (state_next == S_ERR)
      seg_next = SEG_E;
    else if (next_full && phase_next)
      seg_next = SEG_BLANK;
    else if (!dec_valid)
      seg_next = SEG_E;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      SEG       <= 7'h3F;
      LED_FULL  <= 1'b0;
      LED_EMPTY <= 1'b1;
      BUZZ      <= 1'b0;
      ERR       <= 1'b0;
    end else begin
      SEG       <= seg_next;
      LED_FULL  <= full_s1;
      LED_EMPTY <= empty_s1;
      BUZZ      <= buzz_next;
      ERR       <= (state_next == S_ERR);
    end
  end

endmodule

// File: tb/tb_lift_occupancy_display.sv
// Directed bench for lift_occupancy_display with BLINK_HALF=4, BEEP_CYCLES=8.
// Inputs are driven 1 time unit after a rising edge, outputs sampled at the
// same point, so a change shows on the outputs after two ticks.
module tb_lift_occupancy_display;
  import lift_occupancy_display_pkg::*;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       Q0 = 1'b0, Q1 = 1'b0, Q2 = 1'b0, Q3 = 1'b0;
  logic       Full = 1'b0, Empty = 1'b1;
  logic [6:0] SEG;
  logic       LED_FULL, LED_EMPTY, BUZZ, ERR;
  state_t     dbg_state;

  int errors = 0;
  int checks = 0;

  lift_occupancy_display #(
    .BLINK_HALF  (4),
    .BEEP_CYCLES (8),
    .MAX_COUNT   (9)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .Q0        (Q0),
    .Q1        (Q1),
    .Q2        (Q2),
    .Q3        (Q3),
    .Full      (Full),
    .Empty     (Empty),
    .SEG       (SEG),
    .LED_FULL  (LED_FULL),
    .LED_EMPTY (LED_EMPTY),
    .BUZZ      (BUZZ),
    .ERR       (ERR),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  always #5 CLK = ~CLK;

  // Driver tasks
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic drive(input logic [3:0] cnt, input logic full, input logic empty);
    {Q3, Q2, Q1, Q0} = cnt;
    Full  = full;
    Empty = empty;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int buzz_hi;

  initial begin
    // Reset held with random inputs
    RST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      tick(1);
    end
    check("rst_seg", SEG, 7'h3F);
    check("rst_led_empty", LED_EMPTY, 1);
    check("rst_led_full", LED_FULL, 0);
    check("rst_buzz", BUZZ, 0);
    check("rst_err", ERR, 0);
    check("rst_state", dbg_state, S_EMPTY);

    // Release with count 0
    drive(4'd0, 1'b0, 1'b1);
    RST = 1'b1;
    tick(3);
    check("rel_seg", SEG, 7'h3F);
    check("rel_led_empty", LED_EMPTY, 1);
    check("rel_err", ERR, 0);

    // Count 0 -> 3: visible after exactly two ticks
    drive(4'd3, 1'b0, 1'b0);
    tick(1);
    check("c3_t1_seg", SEG, 7'h3F);
    tick(1);
    check("c3_t2_seg", SEG, 7'h4F);
    check("c3_led_empty", LED_EMPTY, 0);
    check("c3_buzz", BUZZ, 0);
    check("c3_state", dbg_state, S_OCC);

    // Count 8, then 9 with Full: 8-cycle beep, blink 6F x4 / 00 x4
    drive(4'd8, 1'b0, 1'b0);
    tick(2);
    check("c8_seg", SEG, 7'h7F);
    drive(4'd9, 1'b1, 1'b0);
    tick(1);
    check("c9_pre_buzz", BUZZ, 0);
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check($sformatf("full_buzz_%0d", i), BUZZ, 1);
      check($sformatf("full_led_%0d", i), LED_FULL, 1);
      check($sformatf("full_seg_%0d", i), SEG, (i < 4) ? 7'h6F : 7'h00);
    end
    tick(1);
    check("full_post_buzz", BUZZ, 0);
    check("full_post_seg", SEG, 7'h6F);
    check("full_post_led", LED_FULL, 1);
    check("full_post_state", dbg_state, S_FULL);

    // Leave Full, then re-enter and abort after 3 beep cycles
    drive(4'd8, 1'b0, 1'b0);
    tick(2);
    check("leave_seg", SEG, 7'h7F);
    check("leave_led_full", LED_FULL, 0);
    drive(4'd9, 1'b1, 1'b0);
    tick(2);
    check("ab_b0", BUZZ, 1);
    tick(2);
    check("ab_b2", BUZZ, 1);
    drive(4'd8, 1'b0, 1'b0);
    tick(1);
    check("ab_b3", BUZZ, 1);
    tick(1);
    check("ab_buzz_off", BUZZ, 0);
    check("ab_seg", SEG, 7'h7F);
    tick(1);
    check("ab_seg_steady", SEG, 7'h7F);
    check("ab_buzz_steady", BUZZ, 0);

    // Re-entry gives a fresh 8-cycle beep
    drive(4'd9, 1'b1, 1'b0);
    tick(1);
    buzz_hi = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (BUZZ) buzz_hi++;
    end
    check("reentry_beep_len", buzz_hi, 8);

    // Error cases
    drive(4'd12, 1'b0, 1'b0);
    tick(2);
    check("e12_seg", SEG, 7'h79);
    check("e12_err", ERR, 1);
    check("e12_buzz", BUZZ, 0);
    check("e12_state", dbg_state, S_ERR);
    drive(4'd5, 1'b0, 1'b1);
    tick(2);
    check("e5_seg", SEG, 7'h79);
    check("e5_err", ERR, 1);
    check("e5_led_empty", LED_EMPTY, 1);
    drive(4'd5, 1'b0, 1'b0);
    tick(2);
    check("ok5_err", ERR, 0);
    check("ok5_seg", SEG, 7'h6D);

    // Reset mid-blink during the beep
    drive(4'd9, 1'b1, 1'b0);
    tick(2);
    check("mb_entry_buzz", BUZZ, 1);
    tick(5);
    check("mb_blank_seg", SEG, 7'h00);
    check("mb_blank_buzz", BUZZ, 1);
    RST = 1'b0;
    #1;
    check("mb_rst_seg", SEG, 7'h3F);
    check("mb_rst_buzz", BUZZ, 0);
    check("mb_rst_led_empty", LED_EMPTY, 1);
    check("mb_rst_led_full", LED_FULL, 0);
    check("mb_rst_err", ERR, 0);
    tick(2);
    check("mb_hold_seg", SEG, 7'h3F);
    RST = 1'b1;
    tick(1);
    check("mb_rel_t1_buzz", BUZZ, 0);
    check("mb_rel_t1_seg", SEG, 7'h3F);
    tick(1);
    check("mb_rel_t2_buzz", BUZZ, 1);
    check("mb_rel_t2_seg", SEG, 7'h6F);
    buzz_hi = 1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (BUZZ) buzz_hi++;
    end
    check("mb_rel_beep_len", buzz_hi, 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
